// File: rtl/ysyx_22050710_sram_responder_pkg.sv
// Shared encodings and derived constants for the SRAM-like bus responder.
package ysyx_22050710_sram_responder_pkg;

    // i_size encodings (informational only)
    localparam logic [1:0] SIZE_1B = 2'd0;
    localparam logic [1:0] SIZE_2B = 2'd1;
    localparam logic [1:0] SIZE_4B = 2'd2;
    localparam logic [1:0] SIZE_8B = 2'd3;

    // i_op encodings
    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    // Number of address bits covered by one data word.
    function automatic int addr_lsb(input int data_wd);
        return $clog2(data_wd / 8);
    endfunction

    localparam int DEF_DATA_WD = 64;
    localparam int ADDR_LSB    = addr_lsb(DEF_DATA_WD);

endpackage

// File: rtl/ysyx_22050710_resp_fifo.sv
// In-order response queue: one entry per accepted request, capturing the
// memory read data one cycle after issue and releasing it once its delay
// timer has expired.
module ysyx_22050710_resp_fifo
    import ysyx_22050710_sram_responder_pkg::*;
#(
    parameter int DATA_WD     = 64,
    parameter int OUTSTANDING = 2,
    parameter int RESP_DELAY  = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic               push_op,
    input  logic [DATA_WD-1:0] mem_rdata,
    output logic               full,
    output logic               pop,
    output logic [DATA_WD-1:0] rdata
);

    localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int CW = $clog2(OUTSTANDING) + 1;
    localparam int TW = (RESP_DELAY > 0) ? $clog2(RESP_DELAY + 1) : 1;

    logic [OUTSTANDING-1:0]              vld;
    logic [OUTSTANDING-1:0]              op;
    logic [OUTSTANDING-1:0]              cap;
    logic [OUTSTANDING-1:0][TW-1:0]      tmr;
    logic [OUTSTANDING-1:0][DATA_WD-1:0] dat;
    logic [PW-1:0]                       head, tail;
    logic [CW-1:0]                       cnt;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(OUTSTANDING - 1)) ? '0 : p + PW'(1);
    endfunction

    // A valid entry is always at least one cycle past its issue, so only the
    // timer gates the head's response.
    assign pop  = vld[head] && (tmr[head] == '0);
    assign full = (cnt == CW'(OUTSTANDING));

    // Uncaptured head can only be in its first cycle: forward memory data.
    always_comb begin
        rdata = '0;
        if (pop && op[head] == OP_READ)
            rdata = cap[head] ? dat[head] : mem_rdata;
    end

    // Entry storage, capture, timers, pointers and occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld  <= '0;
            op   <= '0;
            cap  <= '0;
            tmr  <= '0;
            dat  <= '0;
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            for (int i = 0; i < OUTSTANDING; i++) begin
                if (vld[i] && !cap[i] && !(pop && head == PW'(i))) begin
                    cap[i] <= 1'b1;
                    dat[i] <= (op[i] == OP_WRITE) ? '0 : mem_rdata;
                end
                if (vld[i] && tmr[i] != '0)
                    tmr[i] <= tmr[i] - TW'(1);
            end
            if (pop) begin
                vld[head] <= 1'b0;
                head      <= ptr_next(head);
            end
            // Push after pop so a full queue can refill the freed slot.
            if (push) begin
                vld[tail] <= 1'b1;
                op[tail]  <= push_op;
                cap[tail] <= 1'b0;
                tmr[tail] <= TW'(RESP_DELAY);
                tail      <= ptr_next(tail);
            end
            if (push && !pop)
                cnt <= cnt + CW'(1);
            else if (pop && !push)
                cnt <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/ysyx_22050710_sram_responder.sv
// Slave end of the SRAM-like req/addr_ok/data_ok bus: accepts requests,
// drives the synchronous memory port, and returns in-order responses.
module ysyx_22050710_sram_responder
    import ysyx_22050710_sram_responder_pkg::*;
#(
    parameter int SRAM_ADDR_WD  = 32,
    parameter int SRAM_DATA_WD  = 64,
    parameter int SRAM_WMASK_WD = 8,
    parameter int OUTSTANDING   = 2,
    parameter int RESP_DELAY    = 0
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_req,
    input  logic                     i_op,
    input  logic [1:0]               i_size,
    input  logic [SRAM_ADDR_WD-1:0]  i_addr,
    input  logic [SRAM_WMASK_WD-1:0] i_wstrb,
    input  logic [SRAM_DATA_WD-1:0]  i_wdata,
    output logic                     o_addr_ok,
    output logic                     o_data_ok,
    output logic [SRAM_DATA_WD-1:0]  o_rdata,
    output logic                     o_mem_en,
    output logic                     o_mem_we,
    output logic [SRAM_ADDR_WD-1:0]  o_mem_addr,
    output logic [SRAM_WMASK_WD-1:0] o_mem_wstrb,
    output logic [SRAM_DATA_WD-1:0]  o_mem_wdata,
    input  logic [SRAM_DATA_WD-1:0]  i_mem_rdata
);

    localparam int LSB = addr_lsb(SRAM_DATA_WD);
    localparam logic [SRAM_ADDR_WD-1:0] LSB_MASK =
        (SRAM_ADDR_WD'(1) << LSB) - SRAM_ADDR_WD'(1);

    logic ready;
    logic full;
    logic pop;
    logic accept;
    logic unused_size;

    // Size is carried on the bus but byte lanes come from the strobes.
    assign unused_size = ^i_size;

    // Hold addr_ok low until the first clock after reset release.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) ready <= 1'b0;
        else          ready <= 1'b1;
    end

    // Depends on queue state only, never on i_req.
    assign o_addr_ok   = ready && (!full || pop);
    assign accept      = i_req && o_addr_ok;
    assign o_data_ok   = pop;

    assign o_mem_en    = accept;
    assign o_mem_we    = accept && (i_op == OP_WRITE);
    assign o_mem_addr  = i_addr & ~LSB_MASK;
    assign o_mem_wstrb = i_wstrb;
    assign o_mem_wdata = i_wdata;

    ysyx_22050710_resp_fifo #(
        .DATA_WD     (SRAM_DATA_WD),
        .OUTSTANDING (OUTSTANDING),
        .RESP_DELAY  (RESP_DELAY)
    ) u_fifo (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .push      (accept),
        .push_op   (i_op),
        .mem_rdata (i_mem_rdata),
        .full      (full),
        .pop       (pop),
        .rdata     (o_rdata)
    );

endmodule
